// File: rtl/sw_status_tx.sv
// Switch status reporter: debounces the 9 slide switches and streams an ASCII
// status line ("S" + 9 binary digits + CR LF) to the UART TX on change or on request.
module sw_status_tx #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [8:0] sw_input,
  input  logic       send_req,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic [8:0] sw_stable,
  output logic       busy
);

  localparam logic [0:0]       S_IDLE   = 1'b0;
  localparam logic [0:0]       S_SEND   = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [8:0]       sync1, sync2, cand, snap, stable_nxt;
  logic [CNT_W-1:0] cnt;
  logic [0:0]       state;
  logic [3:0]       k, idx;
  logic             pending, settle, change, req, xfer, last;

  // The whole vector has to sit unchanged for DEBOUNCE_CYCLES before it is accepted
  assign settle     = (sync2 == cand) && (cnt == CNT_LAST);
  assign change     = settle && (cand != sw_stable);
  assign stable_nxt = settle ? cand : sw_stable;
  assign req        = change | send_req;
  assign xfer       = tx_valid & tx_ready;
  assign last       = (k == 4'd11);

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1     <= '0;
      sync2     <= '0;
      cand      <= '0;
      cnt       <= '0;
      sw_stable <= '0;
    end else begin
      sync1 <= sw_input;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt == CNT_LAST) begin
        sw_stable <= cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // snap is only loaded at message start so in-flight bytes never see later changes
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      k       <= '0;
      snap    <= '0;
      pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            snap  <= stable_nxt;
            k     <= '0;
            state <= S_SEND;
          end
        end
        default: begin
          if (xfer && last) begin
            if (pending || req) begin
              snap    <= stable_nxt;
              k       <= '0;
              pending <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            if (xfer) k <= k + 1'b1;
            if (req) pending <= 1'b1;
          end
        end
      endcase
    end
  end

  assign idx = 4'd9 - k;

  always_comb begin
    tx_data = 8'h00;
    if (state == S_SEND) begin
      if (k == 4'd0)       tx_data = 8'h53;
      else if (k <= 4'd9)  tx_data = {7'b0011000, snap[idx]};
      else if (k == 4'd10) tx_data = 8'h0D;
      else                 tx_data = 8'h0A;
    end
  end

  assign tx_valid = (state == S_SEND);
  assign busy     = tx_valid;

endmodule

// File: tb/tb_sw_status_tx.sv
// Directed bench for sw_status_tx with a short debounce window.
module tb_sw_status_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic [8:0] sw_input;
  logic       send_req;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [8:0] sw_stable;
  logic       busy;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  logic [7:0] byte_q[$];
  int         cyc_q[$];

  sw_status_tx #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST), .sw_input(sw_input), .send_req(send_req),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .sw_stable(sw_stable), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Record every byte that will be accepted at the next rising edge
  always @(negedge CLK)
    if (tx_valid && tx_ready && !RST) begin
      byte_q.push_back(tx_data);
      cyc_q.push_back(cyc);
    end

  function automatic logic [7:0] exp_byte(input logic [8:0] v, input int k);
    if (k == 0)  return 8'h53;
    if (k == 10) return 8'h0D;
    if (k == 11) return 8'h0A;
    return v[9-k] ? 8'h31 : 8'h30;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (tx_valid && n < 100) begin
      @(negedge CLK);
      n++;
    end
    #1;
    vectors++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout tx_valid=%b after %0d cycles, need 0", name, tx_valid, n);
    end
  endtask

  task automatic test_reset();
    int hi = 0;
    RST = 1'b1; sw_input = '0; send_req = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({tx_valid, busy, tx_data, sw_stable} !== 19'h0) begin
      errors++;
      $display("FAIL reset_state valid=%b busy=%b data=%h stable=%h, need all 0",
               tx_valid, busy, tx_data, sw_stable);
    end
    repeat (50) begin
      @(negedge CLK);
      if (tx_valid) hi++;
    end
    #1;
    vectors++;
    if (hi != 0 || byte_q.size() != 0 || sw_stable !== 9'h0) begin
      errors++;
      $display("FAIL reset_quiet valid_cycles=%0d bytes=%0d stable=%h, need 0 0 000",
               hi, byte_q.size(), sw_stable);
    end
  endtask

  task automatic test_debounce_msg();
    logic [7:0] exp[12] = '{8'h53, 8'h31, 8'h31, 8'h30, 8'h31, 8'h30,
                            8'h30, 8'h31, 8'h30, 8'h31, 8'h0D, 8'h0A};
    byte_q.delete(); cyc_q.delete();
    @(posedge CLK); #1 sw_input = 9'h1A5;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if (sw_stable !== 9'h000) begin
      errors++;
      $display("FAIL debounce_early stable=%h after 6 edges, need 000", sw_stable);
    end
    @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if (sw_stable !== 9'h1A5 || tx_valid !== 1'b1 || tx_data !== 8'h53) begin
      errors++;
      $display("FAIL debounce_edge7 stable=%h valid=%b data=%h, need 1a5 1 53",
               sw_stable, tx_valid, tx_data);
    end
    wait_idle("msg1");
    vectors++;
    if (byte_q.size() != 12) begin
      errors++;
      $display("FAIL msg1_len bytes=%0d, need 12", byte_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        vectors++;
        if (byte_q[i] !== exp[i] || cyc_q[i] != cyc_q[0] + i) begin
          errors++;
          $display("FAIL msg1_byte%0d got %h at +%0d, need %h at +%0d",
                   i, byte_q[i], cyc_q[i] - cyc_q[0], exp[i], i);
        end
      end
    end
  endtask

  task automatic test_glitch();
    byte_q.delete(); cyc_q.delete();
    @(posedge CLK); #1 sw_input = 9'h1A4;
    repeat (3) @(posedge CLK);
    #1 sw_input = 9'h1A5;
    repeat (20) @(posedge CLK);
    @(negedge CLK); #1;
    vectors++;
    if (sw_stable !== 9'h1A5 || byte_q.size() != 0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch stable=%h bytes=%0d valid=%b, need 1a5 0 0",
               sw_stable, byte_q.size(), tx_valid);
    end
  endtask

  // Ready toggles; a send_req and a switch change both land during message 1
  task automatic test_back_to_back();
    logic       pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = 8'h00;
    int         n;
    bit         done = 1'b0;
    byte_q.delete(); cyc_q.delete();
    for (n = 0; n < 150 && !done; n++) begin
      @(posedge CLK); #1;
      tx_ready = (n % 2 == 0);
      send_req = (n == 0 || n == 6);
      sw_input = (n >= 8) ? 9'h003 : 9'h1A5;
      @(negedge CLK); #1;
      if (pv && !pr) begin
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== pd) begin
          errors++;
          $display("FAIL hold_n%0d valid=%b data=%h, need 1 %h", n, tx_valid, tx_data, pd);
        end
      end
      if (byte_q.size() > 0 && byte_q.size() < 24 && !tx_valid) begin
        vectors++;
        errors++;
        $display("FAIL no_gap_n%0d tx_valid=0 after %0d bytes, need 1", n, byte_q.size());
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
      if (byte_q.size() >= 24 && !tx_valid) done = 1'b1;
    end
    send_req = 1'b0;
    vectors++;
    if (!done) begin
      errors++;
      $display("FAIL b2b_timeout bytes=%0d valid=%b, need 24 0", byte_q.size(), tx_valid);
    end
    tx_ready = 1'b1;
    repeat (20) @(posedge CLK);
    @(negedge CLK); #1;
    vectors++;
    if (byte_q.size() != 24) begin
      errors++;
      $display("FAIL b2b_len bytes=%0d, need 24", byte_q.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        vectors++;
        if (byte_q[i] !== exp_byte(i < 12 ? 9'h1A5 : 9'h003, i % 12)) begin
          errors++;
          $display("FAIL b2b_byte%0d got %h, need %h", i, byte_q[i],
                   exp_byte(i < 12 ? 9'h1A5 : 9'h003, i % 12));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    byte_q.delete(); cyc_q.delete();
    @(posedge CLK); #1 send_req = 1'b1; tx_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge CLK); #1;
      send_req = (i == 2);
    end
    RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK); #1;
    vectors++;
    if ({tx_valid, busy, tx_data, sw_stable} !== 19'h0) begin
      errors++;
      $display("FAIL rst_mid_state valid=%b busy=%b data=%h stable=%h, need all 0",
               tx_valid, busy, tx_data, sw_stable);
    end
    vectors++;
    if (byte_q.size() != 5 || byte_q[0] !== 8'h53 || byte_q[4] !== 8'h30) begin
      errors++;
      $display("FAIL rst_mid_partial bytes=%0d first=%h, need 5 53", byte_q.size(),
               byte_q.size() > 0 ? byte_q[0] : 8'h00);
    end
    byte_q.delete(); cyc_q.delete();
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if (sw_stable !== 9'h000 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_deb_early stable=%h valid=%b, need 000 0", sw_stable, tx_valid);
    end
    @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if (sw_stable !== 9'h003 || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_deb_edge7 stable=%h valid=%b, need 003 1", sw_stable, tx_valid);
    end
    wait_idle("rst_msg");
    repeat (20) @(posedge CLK);
    @(negedge CLK); #1;
    vectors++;
    if (byte_q.size() != 12) begin
      errors++;
      $display("FAIL rst_msg_len bytes=%0d, need 12", byte_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        vectors++;
        if (byte_q[i] !== exp_byte(9'h003, i)) begin
          errors++;
          $display("FAIL rst_msg_byte%0d got %h, need %h", i, byte_q[i], exp_byte(9'h003, i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce_msg();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
